// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage buffers.
//   pipe_state_t     : buffer fill state; the encoding equals the entry count.
//   EXMEM_*          : default widths of the EX/MEM stage bundle.
//   EFF_*            : bit positions inside the side-effect field.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    localparam int EXMEM_DATA_W    = 96;
    localparam int EXMEM_EFF_W     = 5;

    localparam int EFF_BYTE_WE_LSB = 0;
    localparam int EFF_REG_WE      = 4;

endpackage

// File: rtl/pipe_entry_reg.sv
// One buffered pipeline entry: {data, eff, killed}.
//   clk      : clock
//   clr      : synchronous clear, wins over load
//   load     : capture d_* on the next edge
//   d_*      : entry to capture
//   q_*      : held entry
module pipe_entry_reg #(
    parameter int DATA_W = 96,
    parameter int EFF_W  = 5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] d_data,
    input  logic [EFF_W-1:0]  d_eff,
    input  logic              d_killed,
    output logic [DATA_W-1:0] q_data,
    output logic [EFF_W-1:0]  q_eff,
    output logic              q_killed
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q_data   <= '0;
            q_eff    <= '0;
            q_killed <= 1'b0;
        end else if (load) begin
            q_data   <= d_data;
            q_eff    <= d_eff;
            q_killed <= d_killed;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake and optional skid entry.
//
//   state | meaning
//   ------+-------------------------------------------------
//   EMPTY | nothing held, out_valid=0
//   ONE   | head held in main
//   TWO   | head in main, next entry in skid, in_ready=0
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   in_valid/in_ready          : upstream handshake
//   in_kill                    : annul incoming entry (eff cleared or dropped)
//   in_data/in_eff             : incoming payload / side-effect enables
//   flush                      : discard all held entries
//   out_valid/out_ready        : downstream handshake
//   out_data/out_eff/out_killed: head entry
//   occupancy                  : entries held
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W    = EXMEM_DATA_W,
    parameter int EFF_W     = EXMEM_EFF_W,
    parameter int SKID      = 1,
    parameter int KILL_DROP = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_kill,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EFF_W-1:0]  in_eff,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [EFF_W-1:0]  out_eff,
    output logic              out_killed,
    output logic [1:0]        occupancy
);

    localparam bit          DROP    = (KILL_DROP != 0);
    localparam logic [1:0]  MAX_OCC = (SKID != 0) ? 2'd2 : 2'd1;

    pipe_state_t state, state_nxt;
    logic        in_ready_q;
    logic        accept, pop, store;
    logic        main_load, main_from_skid, main_drain;
    logic        skid_load, skid_drain;

    logic [EFF_W-1:0]  in_eff_masked;
    logic [DATA_W-1:0] main_d_data;
    logic [EFF_W-1:0]  main_d_eff;
    logic              main_d_killed;
    logic [DATA_W-1:0] skid_data;
    logic [EFF_W-1:0]  skid_eff;
    logic              skid_killed;

    assign accept        = in_valid & in_ready;
    assign pop           = out_valid & out_ready;
    // With KILL_DROP a killed entry completes the handshake but is never stored.
    assign store         = accept & ~(DROP & in_kill);
    assign in_eff_masked = in_eff & {EFF_W{~in_kill}};

    // in_ready_q is primed to 1 by reset; gating with reset keeps it low while
    // reset is held yet lets it rise in the first cycle after.
    generate
        if (SKID != 0) begin : g_skid_ready
            assign in_ready = in_ready_q & ~reset;
        end else begin : g_flat_ready
            assign in_ready = (~out_valid | out_ready) & ~reset;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != TWO);
        end
    end

    // With SKID=0, ONE & store & ~pop cannot occur (in_ready needs a pop),
    // so the same transition table serves both configurations.
    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_drain     = 1'b0;
        skid_load      = 1'b0;
        skid_drain     = 1'b0;
        case (state)
            EMPTY: begin
                if (store) begin
                    state_nxt = ONE;
                    main_load = 1'b1;
                end
            end
            ONE: begin
                if (store && !pop) begin
                    state_nxt = TWO;
                    skid_load = 1'b1;
                end else if (store && pop) begin
                    main_load = 1'b1;
                end else if (pop) begin
                    state_nxt  = EMPTY;
                    main_drain = 1'b1;
                end
            end
            TWO: begin
                if (pop) begin
                    state_nxt      = ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_drain     = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) state_nxt = EMPTY;
    end

    assign main_d_data   = main_from_skid ? skid_data   : in_data;
    assign main_d_eff    = main_from_skid ? skid_eff    : in_eff_masked;
    assign main_d_killed = main_from_skid ? skid_killed : in_kill;

    // Clearing main on drain keeps out_eff at zero whenever out_valid is low.
    pipe_entry_reg #(.DATA_W(DATA_W), .EFF_W(EFF_W)) u_main (
        .clk      (clk),
        .clr      (reset | flush | main_drain),
        .load     (main_load),
        .d_data   (main_d_data),
        .d_eff    (main_d_eff),
        .d_killed (main_d_killed),
        .q_data   (out_data),
        .q_eff    (out_eff),
        .q_killed (out_killed)
    );

    pipe_entry_reg #(.DATA_W(DATA_W), .EFF_W(EFF_W)) u_skid (
        .clk      (clk),
        .clr      (reset | flush | skid_drain),
        .load     (skid_load),
        .d_data   (in_data),
        .d_eff    (in_eff_masked),
        .d_killed (in_kill),
        .q_data   (skid_data),
        .q_eff    (skid_eff),
        .q_killed (skid_killed)
    );

    assign out_valid = (state != EMPTY);
    assign occupancy = state;

    a_occ_max: assert property (@(posedge clk) disable iff (reset)
        occupancy <= MAX_OCC);
    a_eff_live: assert property (@(posedge clk) disable iff (reset)
        (out_eff != '0) |-> (out_valid && !out_killed));

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int DW = EXMEM_DATA_W;
    localparam int EW = EXMEM_EFF_W;
    localparam logic [EW-1:0] EFF_PAT = EW'((1 << EFF_REG_WE) | (9 << EFF_BYTE_WE_LSB));

    logic          clk, reset, in_valid, in_kill, flush, out_ready;
    logic [DW-1:0] in_data;
    logic [EW-1:0] in_eff;

    logic          in_ready, out_valid, out_killed;
    logic [DW-1:0] out_data;
    logic [EW-1:0] out_eff;
    logic [1:0]    occupancy;

    logic          kd_in_ready, kd_out_valid, kd_out_killed;
    logic [DW-1:0] kd_out_data;
    logic [EW-1:0] kd_out_eff;
    logic [1:0]    kd_occupancy;

    logic          ns_in_ready, ns_out_valid, ns_out_killed;
    logic [DW-1:0] ns_out_data;
    logic [EW-1:0] ns_out_eff;
    logic [1:0]    ns_occupancy;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_stage_buf #(.DATA_W(DW), .EFF_W(EW), .SKID(1), .KILL_DROP(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_kill(in_kill), .in_data(in_data), .in_eff(in_eff), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_eff(out_eff), .out_killed(out_killed), .occupancy(occupancy));

    pipe_stage_buf #(.DATA_W(DW), .EFF_W(EW), .SKID(1), .KILL_DROP(1)) dut_kd (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(kd_in_ready),
        .in_kill(in_kill), .in_data(in_data), .in_eff(in_eff), .flush(flush),
        .out_valid(kd_out_valid), .out_ready(out_ready), .out_data(kd_out_data),
        .out_eff(kd_out_eff), .out_killed(kd_out_killed), .occupancy(kd_occupancy));

    pipe_stage_buf #(.DATA_W(DW), .EFF_W(EW), .SKID(0), .KILL_DROP(0)) dut_ns (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ns_in_ready),
        .in_kill(in_kill), .in_data(in_data), .in_eff(in_eff), .flush(flush),
        .out_valid(ns_out_valid), .out_ready(out_ready), .out_data(ns_out_data),
        .out_eff(ns_out_eff), .out_killed(ns_out_killed), .occupancy(ns_occupancy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        in_valid = 1'b0; in_kill = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_data = '0; in_eff = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [EW-1:0] e);
        in_valid = 1'b1; in_data = d; in_eff = e;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL rst_data: got %h want 0", out_data); else n_pass++;
        n_checks++; if (out_eff !== '0) $display("FAIL rst_eff: got %b want 0", out_eff); else n_pass++;
        n_checks++; if (out_killed !== 1'b0) $display("FAIL rst_killed: got %b want 0", out_killed); else n_pass++;
        n_checks++; if (occupancy !== 2'd0) $display("FAIL rst_occ: got %0d want 0", occupancy); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (ns_in_ready !== 1'b0) $display("FAIL rst_ns_in_ready: got %b want 0", ns_in_ready); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_after_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_single_pass;
        do_reset();
        out_ready = 1'b1;
        push(DW'(32'h70), EFF_PAT);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== DW'(32'h70)) $display("FAIL single_data: got %h want 70", out_data); else n_pass++;
        n_checks++; if (out_eff !== 5'b11001) $display("FAIL single_eff: got %b want 11001", out_eff); else n_pass++;
        n_checks++; if (occupancy !== 2'd1) $display("FAIL single_occ: got %0d want 1", occupancy); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_drain_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_eff !== '0) $display("FAIL single_drain_eff: got %b want 0", out_eff); else n_pass++;
    endtask

    task automatic test_backpressure;
        do_reset();
        out_ready = 1'b0;
        push(DW'(1), 5'b00001);
        push(DW'(2), 5'b00010);
        n_checks++; if (occupancy !== 2'd2) $display("FAIL bp_occ: got %0d want 2", occupancy); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready); else n_pass++;
        // offered but must not be taken while full
        in_valid = 1'b1; in_data = DW'(3); in_eff = 5'b00100;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== DW'(1) || out_eff !== 5'b00001 || occupancy !== 2'd2)
                $display("FAIL bp_hold[%0d]: got v=%b d=%h e=%b o=%0d want v=1 d=1 e=00001 o=2",
                         i, out_valid, out_data, out_eff, occupancy);
            else n_pass++;
        end
        in_valid = 1'b0;
        n_checks++; if (out_data !== DW'(1)) $display("FAIL bp_head: got %h want 1", out_data); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_data !== DW'(2)) $display("FAIL bp_second: got %h want 2", out_data); else n_pass++;
        n_checks++; if (out_eff !== 5'b00010) $display("FAIL bp_second_eff: got %b want 00010", out_eff); else n_pass++;
        n_checks++; if (occupancy !== 2'd1) $display("FAIL bp_occ1: got %0d want 1", occupancy); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", in_ready); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_kill;
        do_reset();
        out_ready = 1'b0;
        in_kill = 1'b1;
        in_valid = 1'b1; in_data = DW'(32'h55); in_eff = 5'b11111;
        #1;
        n_checks++; if (kd_in_ready !== 1'b1) $display("FAIL kd_ready: got %b want 1", kd_in_ready); else n_pass++;
        tick();
        in_valid = 1'b0; in_kill = 1'b0;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL kill_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_eff !== 5'b00000) $display("FAIL kill_eff: got %b want 0", out_eff); else n_pass++;
        n_checks++; if (out_killed !== 1'b1) $display("FAIL kill_flag: got %b want 1", out_killed); else n_pass++;
        n_checks++; if (out_data !== DW'(32'h55)) $display("FAIL kill_data: got %h want 55", out_data); else n_pass++;
        n_checks++; if (kd_out_valid !== 1'b0) $display("FAIL kd_valid: got %b want 0", kd_out_valid); else n_pass++;
        n_checks++; if (kd_occupancy !== 2'd0) $display("FAIL kd_occ: got %0d want 0", kd_occupancy); else n_pass++;
        push(DW'(32'h66), 5'b00011);
        n_checks++; if (kd_out_data !== DW'(32'h66) || kd_out_eff !== 5'b00011 || kd_occupancy !== 2'd1)
            $display("FAIL kd_next: got d=%h e=%b o=%0d want d=66 e=00011 o=1", kd_out_data, kd_out_eff, kd_occupancy);
            else n_pass++;
        n_checks++; if (occupancy !== 2'd2) $display("FAIL kill_then_live_occ: got %0d want 2", occupancy); else n_pass++;
        n_checks++; if (out_killed !== 1'b1 || out_eff !== '0) $display("FAIL kill_head_kept: got k=%b e=%b want k=1 e=0", out_killed, out_eff); else n_pass++;
    endtask

    task automatic test_flush;
        do_reset();
        out_ready = 1'b0;
        push(DW'(32'hA), 5'b00101);
        push(DW'(32'hB), 5'b00110);
        flush = 1'b1; in_valid = 1'b1; in_data = DW'(32'hC); in_eff = 5'b10000; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_checks++; if (occupancy !== 2'd0) $display("FAIL flush_occ: got %0d want 0", occupancy); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_eff !== '0) $display("FAIL flush_eff: got %b want 0", out_eff); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", in_ready); else n_pass++;
        // flush from ONE while in_ready is high: the accept must still be dropped
        push(DW'(32'hA), 5'b00101);
        flush = 1'b1; in_valid = 1'b1; in_data = DW'(32'hD); in_eff = 5'b10001;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tick(); tick();
        n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
            $display("FAIL flush_drop: got v=%b o=%0d want v=0 o=0", out_valid, occupancy); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int bad;
        do_reset();
        out_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_data = DW'(32'h100 + i); in_eff = EW'(i);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== DW'(32'h100 + i) || in_ready !== 1'b1 || occupancy !== 2'd1) begin
                $display("FAIL stream[%0d]: got v=%b d=%h r=%b o=%0d want v=1 d=%h r=1 o=1",
                         i, out_valid, out_data, in_ready, occupancy, DW'(32'h100 + i));
                bad++;
            end else n_pass++;
            if (bad > 5) break;
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL stream_end: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_random_ready;
        logic [DW-1:0] q[$];
        int sent, got;
        logic acc, pp;
        do_reset();
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 2000 && got < 60; cyc++) begin
            in_valid  = (sent < 60);
            in_data   = DW'(32'h200 + sent);
            in_eff    = EW'(sent);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            pp  = out_valid & out_ready;
            acc = in_valid & in_ready;
            if (pp) begin
                n_checks++;
                if (q.size() == 0) $display("FAIL rand_extra: got %h want none", out_data);
                else if (out_data !== q[0]) $display("FAIL rand_order: got %h want %h", out_data, q[0]);
                else n_pass++;
                if (q.size() != 0) void'(q.pop_front());
                got++;
            end
            if (acc) begin
                q.push_back(in_data);
                sent++;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++; if (got != 60 || q.size() != 0)
            $display("FAIL rand_count: got popped=%0d left=%0d want popped=60 left=0", got, q.size()); else n_pass++;
    endtask

    task automatic test_no_skid;
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DW'(32'h31); in_eff = 5'b00001;
        #1;
        n_checks++; if (ns_in_ready !== 1'b1) $display("FAIL ns_ready_empty: got %b want 1", ns_in_ready); else n_pass++;
        tick();
        n_checks++; if (ns_in_ready !== 1'b0 || ns_occupancy !== 2'd1)
            $display("FAIL ns_full: got r=%b o=%0d want r=0 o=1", ns_in_ready, ns_occupancy); else n_pass++;
        out_ready = 1'b1; in_data = DW'(32'h32);
        #1;
        n_checks++; if (ns_in_ready !== 1'b1) $display("FAIL ns_ready_pop: got %b want 1", ns_in_ready); else n_pass++;
        tick();
        n_checks++; if (ns_out_valid !== 1'b1 || ns_out_data !== DW'(32'h32) || ns_occupancy !== 2'd1)
            $display("FAIL ns_replace: got v=%b d=%h o=%0d want v=1 d=32 o=1", ns_out_valid, ns_out_data, ns_occupancy);
            else n_pass++;
        in_valid = 1'b0;
        tick();
        n_checks++; if (ns_out_valid !== 1'b0) $display("FAIL ns_drain: got %b want 0", ns_out_valid); else n_pass++;
    endtask

    task automatic test_reset_mid_two;
        do_reset();
        out_ready = 1'b0;
        push(DW'(32'h41), 5'b00001);
        push(DW'(32'h42), 5'b00010);
        n_checks++; if (occupancy !== 2'd2) $display("FAIL mid_pre_occ: got %0d want 2", occupancy); else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (occupancy !== 2'd0) $display("FAIL mid_occ: got %0d want 0", occupancy); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL mid_ready_in_reset: got %b want 0", in_ready); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_ready_after: got %b want 1", in_ready); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_pass();
        test_backpressure();
        test_kill();
        test_flush();
        test_back_to_back();
        test_random_ready();
        test_no_skid();
        test_reset_mid_two();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
